sce_fet: RTL and testbench

Instruction fetch stage of the SCE core. It is the producer end of the fetch/decode boundary whose consumer is the decode stage.
- Issues in-order word reads to instruction memory.
- Buffers returned words with their PCs in a small prefetch FIFO.
- Presents them to decode over a valid/ready handshake.
- Accepts redirects (flushes) from decode.

---
 rtl/sce_fet_pkg.sv | 23 ++
 rtl/sce_fet_fifo.sv | 67 ++++++
 rtl/sce_fet.sv | 134 +++++++++++++
 tb/tb_sce_fet.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sce_fet_pkg.sv
// Shared types, defaults and helpers for the SCE instruction fetch stage.
package sce_fet_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} fet_state_t;

    localparam int          DEF_AW     = 32;
    localparam int          DEF_DW     = 32;
    localparam int          DEF_DEPTH  = 4;
    localparam logic [31:0] DEF_RST_PC = 32'h0000_0000;
    localparam int          DEF_PC_INC = 4;

    // Instruction FIFO entry layout: instr in the upper bits, pc in the lower bits.
    typedef struct packed {
        logic [DEF_DW-1:0] instr;
        logic [DEF_AW-1:0] pc;
    } fet_entry_t;

    // Counters must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sce_fet_fifo.sv
// Synchronous FIFO with clear; the head is read straight from the storage registers.
module sce_fet_fifo
    import sce_fet_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_AW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_cnt   = r_cnt;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees the slot, so push into a full FIFO is fine when it pops in the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            assert (!(i_push && o_full && !w_pop))
                else $error("sce_fet_fifo: push into full fifo");
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/sce_fet.sv
// SCE instruction fetch: credit-limited in-order memory reads feeding a prefetch FIFO to decode.
//   state   | meaning
//   ST_IDLE | no new requests; in-flight responses still collected or dropped
//   ST_RUN  | issue sequential requests while credit allows
module sce_fet
    import sce_fet_pkg::*;
#(
    parameter int            AW     = DEF_AW,
    parameter int            DW     = DEF_DW,
    parameter int            DEPTH  = DEF_DEPTH,
    parameter logic [AW-1:0] RST_PC = AW'(DEF_RST_PC),
    parameter int            PC_INC = DEF_PC_INC
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_fet_en,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_gnt,
    input  logic          i_imem_rvld,
    input  logic [DW-1:0] i_imem_rdata,
    output logic          o_fet2dec_vld,
    output logic [DW-1:0] o_fet2dec_instr,
    output logic [AW-1:0] o_fet2dec_pc,
    input  logic          i_dec2fet_rdy,
    input  logic          i_dec2fet_flush,
    input  logic [AW-1:0] i_dec2fet_tgt,
    output logic          o_fet_busy
);

    localparam int          CW      = cnt_w(DEPTH);
    localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

    fet_state_t       r_state;
    fet_state_t       w_state_nxt;
    logic [AW-1:0]    r_pc;
    logic [CW-1:0]    r_outst;
    logic [CW-1:0]    r_drop;
    logic             w_req;
    logic             w_gnt;
    logic             w_rsp;
    logic             w_push;
    logic             w_pop;
    logic [CW:0]      w_inflight;
    logic [AW-1:0]    w_rsp_pc;
    logic [DW+AW-1:0] w_head;
    logic [CW-1:0]    w_fifo_cnt;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CW-1:0]    w_pcq_cnt;
    logic             w_pcq_empty;
    logic             w_pcq_full;
    logic             w_unused_flags;

    assign w_inflight = {1'b0, w_fifo_cnt} + {1'b0, r_outst};

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: if (i_fet_en)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!i_fet_en) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!i_rst && (r_state == ST_RUN) && !i_dec2fet_flush && (w_inflight < L_DEPTH)) begin
            w_req = 1'b1;
        end
    end

    // Responses with nothing outstanding (e.g. stragglers after reset) are ignored.
    assign w_gnt  = w_req && i_imem_gnt;
    assign w_rsp  = i_imem_rvld && (r_outst != '0);
    assign w_push = w_rsp && (r_drop == '0) && !i_dec2fet_flush;
    assign w_pop  = !w_fifo_empty && i_dec2fet_rdy && !i_dec2fet_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RST_PC;
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_outst <= r_outst + CW'(w_gnt) - CW'(w_rsp);
            if (i_dec2fet_flush) begin
                r_pc   <= i_dec2fet_tgt;
                r_drop <= r_outst - CW'(w_rsp);
            end else begin
                if (w_gnt) begin
                    r_pc <= r_pc + AW'(PC_INC);
                end
                if (w_rsp && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    sce_fet_fifo #(.DEPTH(DEPTH), .W(AW)) u_pcq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_dec2fet_flush),
        .i_push  (w_gnt),
        .i_din   (r_pc),
        .i_pop   (w_push),
        .o_dout  (w_rsp_pc),
        .o_full  (w_pcq_full),
        .o_empty (w_pcq_empty),
        .o_cnt   (w_pcq_cnt)
    );

    sce_fet_fifo #(.DEPTH(DEPTH), .W(DW+AW)) u_ifq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (i_dec2fet_flush),
        .i_push  (w_push),
        .i_din   ({i_imem_rdata, w_rsp_pc}),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_cnt   (w_fifo_cnt)
    );

    assign w_unused_flags = ^{w_pcq_full, w_pcq_empty, w_pcq_cnt, w_fifo_full};

    assign o_imem_req      = w_req;
    assign o_imem_addr     = r_pc;
    assign o_fet2dec_vld   = !w_fifo_empty;
    assign o_fet2dec_instr = w_head[DW+AW-1:AW];
    assign o_fet2dec_pc    = w_head[AW-1:0];
    assign o_fet_busy      = (r_outst != '0) || (w_fifo_cnt != '0);

endmodule

// File: tb/tb_sce_fet.sv
// Directed bench for sce_fet with a small in-order memory responder; data = addr ^ 0x5A5A0000.
module tb_sce_fet;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_fet_en = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b0;
    logic        i_imem_rvld = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        o_fet2dec_vld;
    logic [31:0] o_fet2dec_instr;
    logic [31:0] o_fet2dec_pc;
    logic        i_dec2fet_rdy = 1'b0;
    logic        i_dec2fet_flush = 1'b0;
    logic [31:0] i_dec2fet_tgt = '0;
    logic        o_fet_busy;

    typedef struct { int rem; logic [31:0] addr; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } pop_t;

    mreq_t mq[$];
    pop_t  got[$];
    int    lat = 1;
    int    n_gnt = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    always #5 i_clk = ~i_clk;

    sce_fet dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_fet_en        (i_fet_en),
        .o_imem_req      (o_imem_req),
        .o_imem_addr     (o_imem_addr),
        .i_imem_gnt      (i_imem_gnt),
        .i_imem_rvld     (i_imem_rvld),
        .i_imem_rdata    (i_imem_rdata),
        .o_fet2dec_vld   (o_fet2dec_vld),
        .o_fet2dec_instr (o_fet2dec_instr),
        .o_fet2dec_pc    (o_fet2dec_pc),
        .i_dec2fet_rdy   (i_dec2fet_rdy),
        .i_dec2fet_flush (i_dec2fet_flush),
        .i_dec2fet_tgt   (i_dec2fet_tgt),
        .o_fet_busy      (o_fet_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_got(input string tag, input int idx, input logic [31:0] pc, input logic [31:0] ins);
        if (got.size() > idx) begin
            chk({tag, "_pc"}, got[idx].pc, pc);
            chk({tag, "_instr"}, got[idx].instr, ins);
        end else begin
            chk({tag, "_count"}, got.size(), idx + 1);
        end
    endtask

    // One clock: sample grant/pop before the edge, then advance the memory model.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        mreq_t       m;
        #1;
        g = o_imem_req && i_imem_gnt;
        a = o_imem_addr;
        if (g) n_gnt++;
        if (o_fet2dec_vld && i_dec2fet_rdy && !i_dec2fet_flush && !i_rst)
            got.push_back('{o_fet2dec_pc, o_fet2dec_instr});
        @(posedge i_clk);
        #1;
        if (i_imem_rvld && mq.size() > 0) m = mq.pop_front();
        i_imem_rvld = 1'b0;
        if (g) begin
            m.rem  = lat;
            m.addr = a;
            mq.push_back(m);
        end
        foreach (mq[k]) if (mq[k].rem > 0) mq[k].rem = mq[k].rem - 1;
        if (mq.size() > 0 && mq[0].rem == 0) begin
            i_imem_rvld  = 1'b1;
            i_imem_rdata = mq[0].addr ^ 32'h5A5A_0000;
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_fet_en = 1'b0; i_imem_gnt = 1'b0;
        i_dec2fet_rdy = 1'b0; i_dec2fet_flush = 1'b0;
        tick(); tick();
        i_rst = 1'b0;
        got.delete();
        n_gnt = 0;
    endtask

    task automatic drain(input string tag, input int max);
        int k = 0;
        while (o_fet_busy && k < max) begin
            tick();
            k++;
        end
        chk({tag, "_drained"}, o_fet_busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // reset state
        tick(); tick();
        chk("rst_req", o_imem_req, 1'b0);
        chk("rst_vld", o_fet2dec_vld, 1'b0);
        chk("rst_busy", o_fet_busy, 1'b0);
        chk("rst_addr", o_imem_addr, 32'h0);

        // 1: streaming, zero-wait grant, latency 1
        i_fet_en = 1'b1; i_dec2fet_rdy = 1'b1; i_imem_gnt = 1'b1; lat = 1;
        i_rst = 1'b0;
        tick();
        chk("t1_req_c0", o_imem_req, 1'b1);
        chk("t1_addr_c0", o_imem_addr, 32'h0);
        chk("t1_vld_c0", o_fet2dec_vld, 1'b0);
        tick();
        chk("t1_addr_c1", o_imem_addr, 32'h4);
        chk("t1_vld_c1", o_fet2dec_vld, 1'b0);
        tick();
        chk("t1_addr_c2", o_imem_addr, 32'h8);
        chk("t1_vld_c2", o_fet2dec_vld, 1'b1);
        chk("t1_pc_c2", o_fet2dec_pc, 32'h0);
        repeat (3) tick();
        i_fet_en = 1'b0;
        drain("t1", 20);
        chk_got("t1_d0", 0, 32'h0, 32'h5A5A_0000);
        chk_got("t1_d1", 1, 32'h4, 32'h5A5A_0004);
        chk_got("t1_d2", 2, 32'h8, 32'h5A5A_0008);

        // 2: decode stalled, credit limits to DEPTH grants
        do_reset();
        lat = 1; i_imem_gnt = 1'b1; i_fet_en = 1'b1;
        tick();
        repeat (9) tick();
        chk("t2_grants", n_gnt, 4);
        chk("t2_req_off", o_imem_req, 1'b0);
        chk("t2_vld", o_fet2dec_vld, 1'b1);
        chk("t2_pc_held", o_fet2dec_pc, 32'h0);
        chk("t2_instr_held", o_fet2dec_instr, 32'h5A5A_0000);
        chk("t2_busy", o_fet_busy, 1'b1);
        i_dec2fet_rdy = 1'b1;
        tick();
        i_dec2fet_rdy = 1'b0;
        #1;
        chk("t2_req_after_pop", o_imem_req, 1'b1);
        chk("t2_addr_after_pop", o_imem_addr, 32'h10);
        chk("t2_pc_next", o_fet2dec_pc, 32'h4);
        chk("t2_pops", got.size(), 1);
        tick(); tick();
        chk("t2_grants_after", n_gnt, 5);
        chk("t2_req_off2", o_imem_req, 1'b0);

        // 3: flush with 3 outstanding and a concurrent response
        do_reset();
        lat = 5; i_imem_gnt = 1'b1; i_dec2fet_rdy = 1'b1; i_fet_en = 1'b1;
        tick();
        tick(); tick(); tick();
        i_imem_gnt = 1'b0;
        tick(); tick();
        chk("t3_grants", n_gnt, 3);
        chk("t3_vld_pre", o_fet2dec_vld, 1'b0);
        i_dec2fet_flush = 1'b1; i_dec2fet_tgt = 32'h100;
        #1;
        chk("t3_no_req_in_flush", o_imem_req, 1'b0);
        tick();
        i_dec2fet_flush = 1'b0; i_imem_gnt = 1'b1;
        #1;
        chk("t3_vld_f1", o_fet2dec_vld, 1'b0);
        chk("t3_req_f1", o_imem_req, 1'b1);
        chk("t3_addr_f1", o_imem_addr, 32'h100);
        repeat (12) tick();
        i_fet_en = 1'b0;
        drain("t3", 40);
        chk_got("t3_d0", 0, 32'h100, 32'h5A5A_0100);
        chk_got("t3_d1", 1, 32'h104, 32'h5A5A_0104);

        // 4: flush with FIFO non-empty, then PC wrap
        lat = 1; i_imem_gnt = 1'b1; i_dec2fet_rdy = 1'b0; i_fet_en = 1'b1;
        tick();
        repeat (3) tick();
        chk("t4_vld_pre_flush", o_fet2dec_vld, 1'b1);
        i_dec2fet_flush = 1'b1; i_dec2fet_tgt = 32'hFFFF_FFFC; i_dec2fet_rdy = 1'b1;
        tick();
        i_dec2fet_flush = 1'b0;
        got.delete();
        #1;
        chk("t4_vld_f1", o_fet2dec_vld, 1'b0);
        chk("t4_addr_tgt", o_imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("t4_addr_wrap", o_imem_addr, 32'h0);
        i_fet_en = 1'b0;
        drain("t4", 20);
        chk_got("t4_d0", 0, 32'hFFFF_FFFC, 32'hA5A5_FFFC);
        chk_got("t4_d1", 1, 32'h0, 32'h5A5A_0000);

        // 5: enable drops with 2 outstanding
        lat = 3; i_imem_gnt = 1'b0; i_dec2fet_rdy = 1'b1; i_fet_en = 1'b1;
        tick();
        i_dec2fet_flush = 1'b1; i_dec2fet_tgt = 32'h200;
        tick();
        i_dec2fet_flush = 1'b0; i_imem_gnt = 1'b1;
        got.delete();
        tick();
        i_fet_en = 1'b0;
        tick();
        i_imem_gnt = 1'b0;
        #1;
        chk("t5_req_off", o_imem_req, 1'b0);
        chk("t5_busy", o_fet_busy, 1'b1);
        k = 0;
        while (o_fet_busy && k < 30) begin
            tick();
            k++;
        end
        chk("t5_busy_fell", o_fet_busy, 1'b0);
        chk("t5_pops_at_idle", got.size(), 2);
        chk_got("t5_d0", 0, 32'h200, 32'h5A5A_0200);
        chk_got("t5_d1", 1, 32'h204, 32'h5A5A_0204);

        // 6: reset with requests in flight; stragglers must be ignored
        lat = 3; i_imem_gnt = 1'b0; i_dec2fet_rdy = 1'b0; i_fet_en = 1'b1;
        tick();
        i_dec2fet_flush = 1'b1; i_dec2fet_tgt = 32'h300;
        tick();
        i_dec2fet_flush = 1'b0; i_imem_gnt = 1'b1;
        repeat (4) tick();
        chk("t6_vld_pre", o_fet2dec_vld, 1'b1);
        chk("t6_busy_pre", o_fet_busy, 1'b1);
        i_rst = 1'b1;
        tick();
        chk("t6_rst_vld", o_fet2dec_vld, 1'b0);
        chk("t6_rst_req", o_imem_req, 1'b0);
        chk("t6_rst_pc", o_imem_addr, 32'h0);
        chk("t6_rst_busy", o_fet_busy, 1'b0);
        i_fet_en = 1'b0; i_imem_gnt = 1'b0; i_rst = 1'b0; i_dec2fet_rdy = 1'b1;
        got.delete();
        repeat (6) tick();
        chk("t6_late_vld", o_fet2dec_vld, 1'b0);
        chk("t6_late_busy", o_fet_busy, 1'b0);
        chk("t6_late_pops", got.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
